ss_wb_arb: RTL

// - Parametrised N-channel Wishbone master arbiter for the SS DMA engine.
// - Successor to the fixed 4-channel gnt/ss_xfer scheme.
// - Each DMA channel presents a Wishbone request; the block grants the single

---
 rtl/ss_wb_arb.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ss_wb_arb.sv
// ss_wb_arb: N-channel Wishbone master arbiter, round-robin grant of one bounded burst at a time.
// Optional: define SS_ARB_PRIO_EN for channel-0 priority with mid-burst preemption.
module ss_wb_arb #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned BURST = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [NCH-1:0]        ch_req,
  input  logic [NCH-1:0]        ch_we,
  input  logic [NCH-1:0]        ch_cab,
  input  logic [NCH*DW/8-1:0]   ch_sel,
  input  logic [NCH*32-1:0]     ch_adr,
  input  logic [NCH*DW-1:0]     ch_dat_o,
  output logic [NCH-1:0]        ch_ack,
  output logic [NCH-1:0]        ch_err,
  output logic [NCH-1:0]        ch_rty,
  output logic [DW-1:0]         ch_dat_i,
  output logic [NCH-1:0]        gnt,
  output logic                  wbm_cyc,
  output logic                  wbm_stb,
  output logic                  wbm_we,
  output logic                  wbm_cab,
  output logic [DW/8-1:0]       wbm_sel,
  output logic [31:0]           wbm_adr,
  output logic [DW-1:0]         wbm_dat_o,
  input  logic [DW-1:0]         wbm_dat_i,
  input  logic                  wbm_ack,
  input  logic                  wbm_err,
  input  logic                  wbm_rty
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = $clog2(NCH);

  typedef enum logic {IDLE, BUS} state_e;

  state_e         state_q, state_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [IW-1:0]  last_q, last_d, idx_q, idx_d, pick_idx;
  logic [7:0]     cnt_q, cnt_d;
  logic           pick_vld, beat_ok, last_beat, req_drop, rel;
  int unsigned    rr_j;
`ifdef SS_ARB_PRIO_EN
  logic           prio_q, prio_d, prio_pick, preempt;
`endif

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    rr_j     = 0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      rr_j = (32'(last_q) + k) % NCH;
      if (!pick_vld && ch_req[rr_j]) begin
        pick_vld = 1'b1;
        pick_idx = rr_j[IW-1:0];
      end
    end
`ifdef SS_ARB_PRIO_EN
    // A ch0 win that round-robin would not have given it leaves the pointer alone.
    prio_pick = 1'b0;
    if (ch_req[0] && pick_idx != '0) begin
      prio_pick = 1'b1;
      pick_idx  = '0;
    end
`endif
  end

  always_comb begin
    wbm_we    = 1'b0;
    wbm_cab   = 1'b0;
    wbm_sel   = '0;
    wbm_adr   = '0;
    wbm_dat_o = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      wbm_we    = wbm_we | (ch_we[i] & gnt_q[i]);
      wbm_cab   = wbm_cab | (ch_cab[i] & gnt_q[i]);
      wbm_sel   = wbm_sel | (ch_sel[i*SW +: SW] & {SW{gnt_q[i]}});
      wbm_adr   = wbm_adr | (ch_adr[i*32 +: 32] & {32{gnt_q[i]}});
      wbm_dat_o = wbm_dat_o | (ch_dat_o[i*DW +: DW] & {DW{gnt_q[i]}});
    end
  end

  // An ack coinciding with err is not a completed beat.
  assign beat_ok   = wbm_ack & ~wbm_err;
  assign last_beat = beat_ok && (cnt_q == 8'(BURST - 1));
  assign req_drop  = ~|(ch_req & gnt_q) & ~wbm_ack;
`ifdef SS_ARB_PRIO_EN
  assign preempt   = ch_req[0] & ~gnt_q[0] & beat_ok;
  assign rel       = last_beat | wbm_err | wbm_rty | req_drop | preempt;
`else
  assign rel       = last_beat | wbm_err | wbm_rty | req_drop;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
`ifdef SS_ARB_PRIO_EN
    prio_d  = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          idx_d           = pick_idx;
          cnt_d           = '0;
          state_d         = BUS;
`ifdef SS_ARB_PRIO_EN
          prio_d          = prio_pick;
`endif
        end
      end
      BUS: begin
        if (beat_ok) cnt_d = cnt_q + 8'd1;
        if (rel) begin
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
`ifdef SS_ARB_PRIO_EN
          if (!(prio_q || (preempt && !last_beat))) last_d = idx_q;
`else
          last_d  = idx_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NCH - 1);
      idx_q   <= '0;
      cnt_q   <= '0;
`ifdef SS_ARB_PRIO_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
`ifdef SS_ARB_PRIO_EN
      prio_q  <= prio_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign wbm_cyc  = (state_q == BUS);
  assign wbm_stb  = (state_q == BUS);
  assign ch_ack   = {NCH{wbm_ack}} & gnt_q;
  assign ch_err   = {NCH{wbm_err}} & gnt_q;
  assign ch_rty   = {NCH{wbm_rty}} & gnt_q;
  assign ch_dat_i = wbm_dat_i;

endmodule
